// File: rtl/usb_stream_bridge_pkg.sv
// Shared types and default parameters for the USB stream bridge.
// The launch FSM state type and the default widths/depths live here.
package usb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_BUSY,
        DRAIN
    } tx_state_t;

    localparam int DEF_DATA_W     = 8;
    localparam int DEF_RX_DEPTH   = 16;
    localparam int DEF_TX_DEPTH   = 16;
    localparam int DEF_TX_TIMEOUT = 255;

endpackage

// File: rtl/usb_stream_bridge_if.sv
// User-side valid/ready streams of the USB stream bridge.
// The bridge takes the slave modport; user logic takes the master modport.
interface usb_stream_bridge_if #(
    parameter int DATA_W = usb_bridge_pkg::DEF_DATA_W
);
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              tx_ready;

    modport slave (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

    modport master (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output tx_data,
        output tx_valid,
        input  tx_ready
    );
endinterface

// File: rtl/usb_stream_bridge_fifo.sv
// First-word fall-through synchronous FIFO with synchronous clear.
// A push while full is still accepted when a pop frees the head slot in the same cycle.
module usb_sync_fifo
    import usb_bridge_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_RX_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Pointers carry one extra wrap bit so full and empty can be told apart.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level   = wr_ptr - rd_ptr;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rd_data = empty ? '0 : mem[rd_ptr[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[ADDR_W-1:0]] <= wr_data;
    end

endmodule

// File: rtl/usb_stream_bridge.sv
// Buffered bridge between the USB controller byte interface and user valid/ready streams.
// RX and TX FIFOs decouple the two sides; a launch FSM paces TX words using core_tx_busy.
module usb_stream_bridge
    import usb_bridge_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RX_DEPTH   = DEF_RX_DEPTH,
    parameter int TX_DEPTH   = DEF_TX_DEPTH,
    parameter int TX_TIMEOUT = DEF_TX_TIMEOUT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic [DATA_W-1:0]           core_rx_data,
    input  logic                        core_rx_valid,
    output logic [DATA_W-1:0]           core_tx_data,
    output logic                        core_tx_send,
    input  logic                        core_tx_busy,
    usb_stream_bridge_if.slave          user,
    output logic [$clog2(RX_DEPTH):0]   rx_level,
    output logic [$clog2(TX_DEPTH):0]   tx_level,
    output logic                        rx_overflow,
    output logic                        tx_timeout
);

    localparam int TIMER_W = $clog2(TX_TIMEOUT + 1);

    logic              rx_full;
    logic              rx_empty;
    logic              rx_pop;
    logic [DATA_W-1:0] rx_head;

    logic              tx_full;
    logic              tx_empty;
    logic              tx_push;
    logic [DATA_W-1:0] tx_head;

    tx_state_t         state_q;
    tx_state_t         state_d;
    logic [TIMER_W-1:0] timer_q;
    logic              launch;
    logic              expire;
    logic              timer_inc;

    assign rx_pop        = ~rx_empty & user.rx_ready;
    assign user.rx_valid = ~rx_empty;
    assign user.rx_data  = rx_head;
    assign user.tx_ready = ~tx_full;
    assign tx_push       = user.tx_valid & ~tx_full;

    usb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push    (core_rx_valid),
        .wr_data (core_rx_data),
        .pop     (rx_pop),
        .rd_data (rx_head),
        .full    (rx_full),
        .empty   (rx_empty),
        .level   (rx_level)
    );

    usb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear   (flush),
        .push    (tx_push),
        .wr_data (user.tx_data),
        .pop     (launch),
        .rd_data (tx_head),
        .full    (tx_full),
        .empty   (tx_empty),
        .level   (tx_level)
    );

    always_ff @(posedge clk) begin
        if (rst || flush) state_q <= IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (launch) state_d = WAIT_BUSY;
            WAIT_BUSY: begin
                if (core_tx_busy) state_d = DRAIN;
                else if (expire)  state_d = IDLE;
            end
            DRAIN:     if (!core_tx_busy) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // The timer counts WAIT_BUSY cycles; it expires on the TX_TIMEOUT-th idle one.
    always_comb begin
        launch    = 1'b0;
        expire    = 1'b0;
        timer_inc = 1'b0;
        case (state_q)
            IDLE:      launch = ~tx_empty & ~core_tx_busy;
            WAIT_BUSY: begin
                timer_inc = ~core_tx_busy;
                expire    = ~core_tx_busy && (timer_q == TIMER_W'(TX_TIMEOUT - 1));
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            core_tx_data <= '0;
            core_tx_send <= 1'b0;
            timer_q      <= '0;
            tx_timeout   <= 1'b0;
            rx_overflow  <= 1'b0;
        end else begin
            core_tx_send <= launch;
            if (launch) begin
                core_tx_data <= tx_head;
                timer_q      <= '0;
            end else if (timer_inc) begin
                timer_q <= timer_q + 1'b1;
            end
            if (expire) tx_timeout <= 1'b1;
            if (core_rx_valid && rx_full && !rx_pop) rx_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_usb_stream_bridge.sv
// Scoreboard bench for usb_stream_bridge: stimulus queues expected words, a negedge
// monitor pops and compares them whenever the DUT presents RX data or a TX launch.
module tb_usb_stream_bridge;
    import usb_bridge_pkg::*;

    logic       clk;
    logic       rst;
    logic       flush;
    logic [7:0] core_rx_data;
    logic       core_rx_valid;
    logic [7:0] core_tx_data;
    logic       core_tx_send;
    logic       core_tx_busy;
    logic [4:0] rx_level;
    logic [4:0] tx_level;
    logic       rx_overflow;
    logic       tx_timeout;

    usb_stream_bridge_if #(.DATA_W(8)) user_if ();

    usb_stream_bridge #(
        .DATA_W     (8),
        .RX_DEPTH   (16),
        .TX_DEPTH   (16),
        .TX_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .core_rx_data  (core_rx_data),
        .core_rx_valid (core_rx_valid),
        .core_tx_data  (core_tx_data),
        .core_tx_send  (core_tx_send),
        .core_tx_busy  (core_tx_busy),
        .user          (user_if.slave),
        .rx_level      (rx_level),
        .tx_level      (tx_level),
        .rx_overflow   (rx_overflow),
        .tx_timeout    (tx_timeout)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    int   sends_seen   = 0;
    bit   prev_send    = 1'b0;
    bit   model_en     = 1'b0;
    bit   busy_pend    = 1'b0;
    int   busy_cnt     = 0;
    logic [7:0] rx_exp[$];
    logic [7:0] tx_exp[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exhausted, got no finish, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One controller receive strobe; the word is expected on readout only if stored.
    task automatic applyStimulus(input logic [7:0] data, input bit stored);
        core_rx_data  = data;
        core_rx_valid = 1'b1;
        if (stored) rx_exp.push_back(data);
        tick();
        core_rx_valid = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] data, input bit expect_sent);
        user_if.tx_data  = data;
        user_if.tx_valid = 1'b1;
        if (expect_sent) tx_exp.push_back(data);
        tick();
        user_if.tx_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        rx_exp.delete();
        tx_exp.delete();
        tick();
        flush = 1'b0;
    endtask

    task automatic wait_tx_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (tx_exp.size() == 0) break;
            tick();
        end
        checkOutput("tx_drain", tx_exp.size(), 0);
    endtask

    // Controller model: raises busy one cycle after a send and holds it for 4 cycles.
    always @(posedge clk) begin
        #1;
        if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) core_tx_busy = 1'b0;
        end
        if (busy_pend) begin
            core_tx_busy = 1'b1;
            busy_cnt     = 4;
            busy_pend    = 1'b0;
        end
        if (model_en && core_tx_send) busy_pend = 1'b1;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (user_if.rx_valid && user_if.rx_ready) begin
                if (rx_exp.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL rx_unexpected: got 0x%0h, expected no word", user_if.rx_data);
                end else begin
                    checkOutput("rx_data", user_if.rx_data, rx_exp.pop_front());
                end
            end
            if (core_tx_send) begin
                sends_seen++;
                if (tx_exp.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL tx_unexpected: got send of 0x%0h, expected no send", core_tx_data);
                end else begin
                    checkOutput("core_tx_data", core_tx_data, tx_exp.pop_front());
                end
                checkOutput("tx_send_gap", prev_send, 0);
                checkOutput("tx_send_busy", core_tx_busy, 0);
            end
            prev_send = core_tx_send;
        end
    end

    initial begin
        int base_sends;
        rst              = 1'b1;
        flush            = 1'b0;
        core_rx_data     = '0;
        core_rx_valid    = 1'b0;
        core_tx_busy     = 1'b0;
        user_if.rx_ready = 1'b0;
        user_if.tx_data  = '0;
        user_if.tx_valid = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        $display("[TB] reset state");
        checkOutput("rst_rx_level", rx_level, 0);
        checkOutput("rst_tx_level", tx_level, 0);
        checkOutput("rst_rx_valid", user_if.rx_valid, 0);
        checkOutput("rst_rx_data", user_if.rx_data, 0);
        checkOutput("rst_tx_ready", user_if.tx_ready, 1);
        checkOutput("rst_core_tx_send", core_tx_send, 0);
        checkOutput("rst_core_tx_data", core_tx_data, 0);
        checkOutput("rst_rx_overflow", rx_overflow, 0);
        checkOutput("rst_tx_timeout", tx_timeout, 0);

        $display("[TB] RX three words, then readout");
        applyStimulus(8'h11, 1'b1);
        checkOutput("rx_valid_latency", user_if.rx_valid, 1);
        applyStimulus(8'h22, 1'b1);
        applyStimulus(8'h33, 1'b1);
        checkOutput("rx_level_3", rx_level, 3);
        checkOutput("rx_head_11", user_if.rx_data, 8'h11);
        user_if.rx_ready = 1'b1;
        repeat (3) tick();
        user_if.rx_ready = 1'b0;
        checkOutput("rx_level_0", rx_level, 0);

        $display("[TB] RX fill, full push+pop, overflow");
        do_flush();
        for (int i = 0; i < 16; i++) applyStimulus(8'h40 + 8'(i), 1'b1);
        checkOutput("rx_level_full", rx_level, 16);
        checkOutput("rx_no_ovf_full", rx_overflow, 0);
        user_if.rx_ready = 1'b1;
        applyStimulus(8'h60, 1'b1);
        user_if.rx_ready = 1'b0;
        checkOutput("rx_level_pushpop", rx_level, 16);
        checkOutput("rx_no_ovf_pushpop", rx_overflow, 0);
        applyStimulus(8'h61, 1'b0);
        checkOutput("rx_level_ovf", rx_level, 16);
        checkOutput("rx_overflow_set", rx_overflow, 1);
        user_if.rx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (!user_if.rx_valid) break;
            tick();
        end
        user_if.rx_ready = 1'b0;
        checkOutput("rx_drained", rx_level, 0);
        checkOutput("rx_exp_empty", rx_exp.size(), 0);

        $display("[TB] TX two words with busy controller");
        model_en   = 1'b1;
        base_sends = sends_seen;
        push_tx(8'hA5, 1'b1);
        push_tx(8'h5A, 1'b1);
        wait_tx_drain(60);
        repeat (8) tick();
        checkOutput("tx_send_count", sends_seen - base_sends, 2);
        checkOutput("tx_last_data", core_tx_data, 8'h5A);
        checkOutput("tx_level_0", tx_level, 0);
        checkOutput("tx_no_timeout", tx_timeout, 0);

        $display("[TB] TX timeout with silent controller");
        model_en = 1'b0;
        push_tx(8'h77, 1'b1);
        repeat (4) tick();
        checkOutput("tx_timeout_early", tx_timeout, 0);
        tick();
        checkOutput("tx_timeout_set", tx_timeout, 1);
        push_tx(8'h78, 1'b1);
        wait_tx_drain(20);
        repeat (8) tick();

        $display("[TB] flush during DRAIN");
        model_en = 1'b1;
        push_tx(8'hB0, 1'b1);
        for (int i = 1; i < 6; i++) push_tx(8'hB0 + 8'(i), 1'b0);
        checkOutput("tx_level_5", tx_level, 5);
        user_if.tx_data  = 8'hEE;
        user_if.tx_valid = 1'b1;
        core_rx_data     = 8'hCC;
        core_rx_valid    = 1'b1;
        do_flush();
        user_if.tx_valid = 1'b0;
        core_rx_valid    = 1'b0;
        checkOutput("flush_tx_level", tx_level, 0);
        checkOutput("flush_rx_level", rx_level, 0);
        checkOutput("flush_rx_overflow", rx_overflow, 0);
        checkOutput("flush_tx_timeout", tx_timeout, 0);
        checkOutput("flush_core_tx_send", core_tx_send, 0);
        checkOutput("flush_tx_ready", user_if.tx_ready, 1);
        repeat (10) tick();
        checkOutput("post_flush_tx_level", tx_level, 0);
        checkOutput("final_tx_exp_empty", tx_exp.size(), 0);
        checkOutput("final_rx_exp_empty", rx_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
